// File: rtl/fpu_seq_pkg.sv
// Shared types and helpers for the FPU operation sequencer.
package fpu_seq_pkg;

  typedef enum logic [1:0] {
    ADD = 2'b00,
    SUB = 2'b01,
    MUL = 2'b10,
    DIV = 2'b11
  } fpu_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  localparam logic [31:0] FP_POS_INF = 32'h7F80_0000;

  // Cycles allowed for the unit path selected by op.
  function automatic int unsigned lat_of(input fpu_op_e op,
                                         input int unsigned add_lat,
                                         input int unsigned sub_lat,
                                         input int unsigned mul_lat,
                                         input int unsigned div_lat);
    unique case (op)
      ADD:     return add_lat;
      SUB:     return sub_lat;
      MUL:     return mul_lat;
      default: return div_lat;
    endcase
  endfunction

endpackage

// File: rtl/fpu_result_select.sv
// Result mux over the four shared FP units plus divide-by-zero detect.
module fpu_result_select
  import fpu_seq_pkg::*;
(
  input  fpu_op_e     op,
  input  logic [31:0] add_res,
  input  logic [31:0] sub_res,
  input  logic [31:0] mul_res,
  input  logic [31:0] div_res,
  input  logic [30:0] b_mag,
  output logic [31:0] result,
  output logic        dz
);

  // Pick the unit output for the latched op; values pass through untouched.
  always_comb begin
    result = '0;
    unique case (op)
      ADD:     result = add_res;
      SUB:     result = sub_res;
      MUL:     result = mul_res;
      default: result = div_res;
    endcase
  end

  // Magnitude-only compare so both +0 and -0 divisors flag.
  assign dz = (op == DIV) && (b_mag == '0);

endmodule

// File: rtl/fpu_op_sequencer.sv
// Single-issue sequencer sharing the combinational FP units with one requester.
module fpu_op_sequencer
  import fpu_seq_pkg::*;
#(
  parameter int unsigned ADD_LAT = 1,
  parameter int unsigned SUB_LAT = 1,
  parameter int unsigned MUL_LAT = 2,
  parameter int unsigned DIV_LAT = 4,
  parameter int unsigned TAG_W   = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [1:0]       req_op,
  input  logic [31:0]      req_a,
  input  logic [31:0]      req_b,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      unit_a,
  output logic [31:0]      unit_b,
  input  logic [31:0]      add_res,
  input  logic [31:0]      sub_res,
  input  logic [31:0]      mul_res,
  input  logic [31:0]      div_res,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [31:0]      resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             resp_dz,
  output logic             busy
);

  localparam int unsigned MAX_AS  = (ADD_LAT > SUB_LAT) ? ADD_LAT : SUB_LAT;
  localparam int unsigned MAX_MD  = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int unsigned MAX_LAT = (MAX_AS > MAX_MD) ? MAX_AS : MAX_MD;
  // Counter only ever holds LAT-1, so clog2(MAX_LAT) bits suffice.
  localparam int unsigned CNT_W   = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  seq_state_e       state;
  fpu_op_e          op_q;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;
  logic [31:0]      sel_res;
  logic             sel_dz;

  assign req_ready  = (state == IDLE);
  assign resp_valid = (state == DONE);
  assign busy       = (state != IDLE);

  fpu_result_select u_sel (
    .op      (op_q),
    .add_res (add_res),
    .sub_res (sub_res),
    .mul_res (mul_res),
    .div_res (div_res),
    .b_mag   (unit_b[30:0]),
    .result  (sel_res),
    .dz      (sel_dz)
  );

  // FSM, latency counter, operand and response registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      op_q        <= ADD;
      tag_q       <= '0;
      cnt         <= '0;
      unit_a      <= '0;
      unit_b      <= '0;
      resp_result <= '0;
      resp_tag    <= '0;
      resp_dz     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            op_q   <= fpu_op_e'(req_op);
            tag_q  <= req_tag;
            unit_a <= req_a;
            unit_b <= req_b;
            cnt    <= CNT_W'(lat_of(fpu_op_e'(req_op), ADD_LAT, SUB_LAT,
                                    MUL_LAT, DIV_LAT) - 1);
            state  <= EXEC;
          end
        end
        EXEC: begin
          if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
          end else begin
            resp_result <= sel_res;
            resp_tag    <= tag_q;
            resp_dz     <= sel_dz;
            state       <= DONE;
          end
        end
        DONE: begin
          // No accept here: req_ready only rises once back in IDLE.
          if (resp_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fpu_op_sequencer.sv
// Randomized self-checking bench: default instance (0) and latency override (1).
module tb_fpu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid [2];
  logic        req_ready [2];
  logic [1:0]  req_op    [2];
  logic [31:0] req_a     [2];
  logic [31:0] req_b     [2];
  logic [3:0]  req_tag   [2];
  logic [31:0] unit_a    [2];
  logic [31:0] unit_b    [2];
  logic [31:0] add_res   [2];
  logic [31:0] sub_res   [2];
  logic [31:0] mul_res   [2];
  logic [31:0] div_res   [2];
  logic        resp_valid[2];
  logic        resp_ready[2];
  logic [31:0] resp_result[2];
  logic [3:0]  resp_tag  [2];
  logic        resp_dz   [2];
  logic        busy      [2];

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Stand-in unit behaviour: distinct per op so a wrong selection is visible.
  function automatic logic [31:0] umodel(input logic [1:0] op,
                                         input logic [31:0] a, input logic [31:0] b);
    case (op)
      2'd0:    return a + b;
      2'd1:    return a - b;
      2'd2:    return {a[15:0], b[15:0]} ^ 32'h5A5A_3C3C;
      default: return a ^ {b[7:0], b[31:8]} ^ 32'hC3C3_0F0F;
    endcase
  endfunction

  // Expected latency per instance and op.
  function automatic int exp_lat(input int d, input logic [1:0] op);
    int t0 [4] = '{1, 1, 2, 4};
    int t1 [4] = '{3, 1, 2, 1};
    return (d == 0) ? t0[op] : t1[op];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_units
    assign add_res[g] = umodel(2'd0, unit_a[g], unit_b[g]);
    assign sub_res[g] = umodel(2'd1, unit_a[g], unit_b[g]);
    assign mul_res[g] = umodel(2'd2, unit_a[g], unit_b[g]);
    assign div_res[g] = umodel(2'd3, unit_a[g], unit_b[g]);
  end

  fpu_op_sequencer dut0 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_op(req_op[0]),
    .req_a(req_a[0]), .req_b(req_b[0]), .req_tag(req_tag[0]),
    .unit_a(unit_a[0]), .unit_b(unit_b[0]),
    .add_res(add_res[0]), .sub_res(sub_res[0]), .mul_res(mul_res[0]), .div_res(div_res[0]),
    .resp_valid(resp_valid[0]), .resp_ready(resp_ready[0]), .resp_result(resp_result[0]),
    .resp_tag(resp_tag[0]), .resp_dz(resp_dz[0]), .busy(busy[0])
  );

  fpu_op_sequencer #(.ADD_LAT(3), .DIV_LAT(1)) dut1 (
    .clk(clk), .reset(reset),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_op(req_op[1]),
    .req_a(req_a[1]), .req_b(req_b[1]), .req_tag(req_tag[1]),
    .unit_a(unit_a[1]), .unit_b(unit_b[1]),
    .add_res(add_res[1]), .sub_res(sub_res[1]), .mul_res(mul_res[1]), .div_res(div_res[1]),
    .resp_valid(resp_valid[1]), .resp_ready(resp_ready[1]), .resp_result(resp_result[1]),
    .resp_tag(resp_tag[1]), .resp_dz(resp_dz[1]), .busy(busy[1])
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One transaction; called at a negedge, returns at the negedge after the response handshake.
  task automatic do_op(input int d, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] tag, input int hold);
    int k;
    logic [31:0] er;
    logic        edz;
    k = 0;
    while (req_ready[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("idle_wait", 64'(k < 50), 64'(1));
    req_valid[d] = 1'b1; req_op[d] = op; req_a[d] = a; req_b[d] = b; req_tag[d] = tag;
    resp_ready[d] = (hold == 0);
    @(negedge clk);
    // Scribble over the request lines: they must be ignored from here on.
    req_valid[d] = 1'b0; req_op[d] = 2'($urandom_range(0, 3));
    req_a[d] = $urandom; req_b[d] = $urandom; req_tag[d] = 4'($urandom_range(0, 15));
    check("accept_rdy_busy", 64'({req_ready[d], busy[d], resp_valid[d]}), 64'(3'b010));
    check("unit_a", 64'(unit_a[d]), 64'(a));
    check("unit_b", 64'(unit_b[d]), 64'(b));
    k = 0;
    while (resp_valid[d] !== 1'b1 && k < 50) begin @(negedge clk); k++; end
    check("latency", 64'(k), 64'(exp_lat(d, op)));
    er  = umodel(op, a, b);
    edz = (op == 2'd3) && (b[30:0] == 31'd0);
    check("result", 64'(resp_result[d]), 64'(er));
    check("tag", 64'(resp_tag[d]), 64'(tag));
    check("dz", 64'(resp_dz[d]), 64'(edz));
    for (int i = 0; i < hold; i++) begin
      req_valid[d] = 1'b1;
      @(negedge clk);
      check("bp_hold", 64'({resp_valid[d], req_ready[d], resp_result[d], resp_tag[d], resp_dz[d]}),
            64'({1'b1, 1'b0, er, tag, edz}));
      check("bp_unit_a", 64'(unit_a[d]), 64'(a));
    end
    resp_ready[d] = 1'b1;
    @(negedge clk);
    req_valid[d] = 1'b0;
    check("handshake", 64'({resp_valid[d], req_ready[d], busy[d]}), 64'(3'b010));
    check("no_accept_in_done", 64'(unit_a[d]), 64'(a));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  op;
    logic [31:0] a, b;
    logic        s;
    reset = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0; req_op[d] = '0; req_a[d] = '0; req_b[d] = '0;
      req_tag[d] = '0; resp_ready[d] = 1'b0;
    end
    #12;
    check("rst_outs", 64'({resp_valid[0], busy[0], resp_dz[0], resp_tag[0], resp_result[0]}), 64'(0));
    check("rst_units", 64'({unit_a[0], unit_b[0]}), 64'(0));
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check("rst_ready", 64'({req_ready[0], req_ready[1]}), 64'(2'b11));

    // Directed cases from the plan.
    do_op(0, 2'd2, 32'h3F80_0000, 32'h4000_0000, 4'd3, 0);
    do_op(0, 2'd0, 32'h3FC0_0000, 32'h4010_0000, 4'd1, 0);
    do_op(0, 2'd1, 32'h4000_0000, 32'h3F80_0000, 4'd2, 0);
    do_op(0, 2'd3, 32'h40A0_0000, 32'h0000_0000, 4'd4, 0);
    do_op(0, 2'd3, 32'h40A0_0000, 32'h8000_0000, 4'd5, 1);
    do_op(0, 2'd3, 32'h40C0_0000, 32'h4000_0000, 4'd6, 0);
    do_op(0, 2'd2, 32'hBFC0_0000, 32'h4040_0000, 4'd7, 5);

    // Randomized traffic with random backpressure and idle gaps.
    for (int n = 0; n < 40; n++) begin
      op = 2'($urandom_range(0, 3));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 3) == 0) begin
        s = 1'($urandom_range(0, 1));
        b = {s, 31'd0};
      end
      do_op(0, op, a, b, 4'($urandom_range(0, 15)), int'($urandom_range(0, 3)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Latency override instance.
    do_op(1, 2'd3, 32'h40C0_0000, 32'h4000_0000, 4'd9, 0);
    do_op(1, 2'd0, 32'h3FC0_0000, 32'h4010_0000, 4'd10, 0);
    for (int n = 0; n < 8; n++)
      do_op(1, 2'($urandom_range(0, 3)), $urandom, $urandom, 4'($urandom_range(0, 15)),
            int'($urandom_range(0, 2)));

    // Asynchronous reset in the middle of a DIV: no response, everything clears.
    req_valid[0] = 1'b1; req_op[0] = 2'd3; req_a[0] = 32'h1234_5678; req_b[0] = 32'h4000_0000;
    req_tag[0] = 4'hE; resp_ready[0] = 1'b1;
    @(negedge clk); req_valid[0] = 1'b0;
    @(negedge clk);
    check("pre_rst_busy", 64'(busy[0]), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("midrst_state", 64'({resp_valid[0], busy[0], req_ready[0]}), 64'(3'b001));
    check("midrst_units", 64'({unit_a[0], unit_b[0]}), 64'(0));
    check("midrst_resp", 64'({resp_result[0], resp_tag[0], resp_dz[0]}), 64'(0));
    @(negedge clk); reset = 1'b0;
    repeat (5) begin
      @(negedge clk);
      check("midrst_no_resp", 64'(resp_valid[0]), 64'(0));
    end
    do_op(0, 2'd0, 32'h3FC0_0000, 32'h4010_0000, 4'd8, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fpu_op_sequencer.md
Name: fpu_op_sequencer

Overview:
Single-issue controller that shares the four combinational IEEE-754 single-precision units (adder, subtractor, multiplier, divider) with one requester, such as the RISC-V execute stage.
- Accepts one operation per valid/ready handshake and registers the operands onto the shared unit inputs.
- Waits a per-operation multicycle latency so the unit paths need not close in one cycle.
- Captures the selected result and returns it with the request tag over a valid/ready response channel.

Parameters:
ADD_LAT, 1, cycles allowed for adder path (>=1)
SUB_LAT, 1, cycles allowed for subtractor path (>=1)
MUL_LAT, 2, cycles allowed for multiplier path (>=1)
DIV_LAT, 4, cycles allowed for divider path (>=1)
TAG_W, 4, width of request/response tag

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high reset
req_valid  in  1  request present
req_ready  out  1  sequencer can accept (high only in IDLE)
req_op  in  2  00 ADD, 01 SUB (a-b), 10 MUL, 11 DIV (a/b)
req_a  in  32  operand A, IEEE-754 single
req_b  in  32  operand B, IEEE-754 single
req_tag  in  TAG_W  requester tag, echoed on the response
unit_a  out  32  registered operand A to all four units
unit_b  out  32  registered operand B to all four units
add_res  in  32  adder output
sub_res  in  32  subtractor output
mul_res  in  32  multiplier output
div_res  in  32  divider output
resp_valid  out  1  result available
resp_ready  in  1  consumer accepts result
resp_result  out  32  captured result
resp_tag  out  TAG_W  tag of the completed op
resp_dz  out  1  divide-by-zero flag (DIV and |b| == 0)
busy  out  1  state != IDLE

Behaviour:
- One clock (clk). Reset is asynchronous and active-high (reset). While reset is high, all state and outputs clear immediately:
  - state = IDLE; req_ready = 1 once reset deasserts.
  - resp_valid = 0, resp_result = 0, resp_tag = 0, resp_dz = 0, busy = 0.
  - unit_a = 0, unit_b = 0, latency counter = 0.
- FSM states: IDLE, EXEC, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready at an edge:
    - Latch op and tag.
    - Load unit_a/unit_b from req_a/req_b.
    - Load counter = LAT[op] - 1 and go to EXEC.
  - Otherwise unit_a/unit_b hold their previous values.
- EXEC:
  - req_ready = 0; unit_a/unit_b held stable.
  - While counter != 0, decrement by 1 per cycle.
  - At the edge where counter == 0:
    - Capture the result for the latched op into resp_result.
    - Set resp_tag to the latched tag.
    - Set resp_dz = (op == DIV) & (unit_b[30:0] == 0). The sign of a zero divisor is ignored.
    - Go to DONE.
- DONE:
  - resp_valid = 1. resp_result, resp_tag and resp_dz are stable until the handshake.
  - On resp_valid & resp_ready: go to IDLE, clear resp_valid.
  - No new request is accepted in the same cycle. req_ready rises the following cycle, so issue is back-to-back with one bubble.
- Latency: resp_valid rises LAT[op] rising edges after the accepting edge (ADD 1, SUB 1, MUL 2, DIV 4 by default). Minimum round trip per op is LAT + 1 cycles when resp_ready is held high.
- resp_result is the captured unit output, unmodified. The sequencer does no rounding or special-case substitution, except raising resp_dz.
- busy = (state != IDLE).
- req_op/req_a/req_b/req_tag are ignored outside the IDLE handshake. req_valid may drop without handshake with no effect.
- Reset asserted mid-EXEC or mid-DONE: the op is abandoned with no response; the FSM returns to IDLE immediately.

Decomposition:
- Package fpu_seq_pkg:
  - fpu_op_e enum (ADD=2'b00, SUB=2'b01, MUL=2'b10, DIV=2'b11).
  - seq_state_e enum (IDLE, EXEC, DONE).
  - Function lat_of(op) returning the parameterised latency.
  - Constant FP_POS_INF = 32'h7F800000.
- Sub-module fpu_result_select:
  - Combinational 4:1 mux of add/sub/mul/div results by op.
  - Divide-by-zero detection.
- FSM, counter and registers live in the top module.

Test Plan:
- MUL 3F800000 x 40000000, tag 3, resp_ready=1 -> resp_valid exactly 2 cycles after accept; result 40000000, tag 3, dz 0; req_ready low for 3 cycles.
- ADD 3FC00000 + 40100000, then SUB 40000000 - 3F800000 back-to-back -> results 40700000 then 3F800000, each 1 cycle after its accept; one-cycle bubble between accepts.
- DIV 40A00000 / 00000000 (also b = 80000000) -> resp_dz 1, resp_result = divider output (7F800000 with the real divider); DIV 40C00000 / 40000000 -> 40400000, dz 0, 4-cycle latency.
- Backpressure: hold resp_ready=0 for 5 cycles on MUL BFC00000 x 40400000 -> resp_valid, result C0900000 and tag stable; req_valid held high is not accepted until 1 cycle after the handshake.
- Assert reset asynchronously mid-EXEC of a DIV -> resp_valid, busy and unit_a/unit_b clear immediately with no response; the next ADD after reset completes normally.
- Parameter override DIV_LAT=1, ADD_LAT=3 -> latencies measured as 1 and 3 cycles respectively.
